// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, MSB first, with a one-deep holding register.
// A received byte is presented on dataOut with a level-sensitive valid flag
// that the consumer clears with a one-cycle read strobe. Stop-bit errors and
// lost bytes are reported through the sticky frameErr and overrun flags.
module uart_rx #(
    parameter int unsigned DELAY_FRAMES = 234,               // clock cycles per bit
    parameter int unsigned HALF_FRAMES  = DELAY_FRAMES / 2   // start edge to mid-start-bit
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] dataOut,
    output logic       valid,
    input  logic       read,
    output logic       frameErr,
    output logic       overrun
);

    // Bit-period counter width matches the emitter so the two stay interchangeable.
    localparam int unsigned CNT_W = 25;

    // Terminal counts: comparing against N-1 is the same test as counter+1 == N.
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_FRAMES - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(HALF_FRAMES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    // Fewer than four cycles per bit leaves no room for the mid-bit sample.
    if (DELAY_FRAMES < 4) begin : g_bad_delay
        $error("uart_rx: DELAY_FRAMES must be at least 4");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchroniser: sync_q[0] is the metastability catcher, sync_q[1] is rxs.
    logic [1:0]       sync_q,      sync_d;
    logic             rxs;

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [2:0]       bit_idx_q,   bit_idx_d;
    logic [7:0]       shift_q,     shift_d;
    logic [7:0]       data_q,      data_d;
    logic             valid_q,     valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q,   overrun_d;

    assign rxs = sync_q[1];

    // Shift the raw line into the two-stage synchroniser.
    always_comb begin
        sync_d = {sync_q[0], rx};
    end

    // Synchroniser flops; preset to the idle-high line level so reset never
    // looks like a start bit.
    // NOTE: registers are written with <= so every flop samples the values
    // from before the edge; blocking = here would collapse the two stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Next-state, bit timing, shift register and handshake flags.
    // NOTE: every _d signal gets its hold value first; a path that forgot to
    // assign one would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;

        // The consumer's read is applied first so that an event completing on
        // the same edge is layered on top of the cleared flags.
        if (read) begin
            valid_d     = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs) begin
                    state_d = S_START;
                end
            end

            S_START: begin
                if (cnt_q == HALF_LAST) begin
                    // Mid-start-bit: a line that has gone high again was noise.
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rxs ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_DATA: begin
                if (cnt_q == DELAY_LAST) begin
                    // First data bit lands in bit 7 to match the emitter's order.
                    cnt_d                      = '0;
                    shift_d[3'd7 - bit_idx_q]  = rxs;
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_STOP: begin
                if (cnt_q == DELAY_LAST) begin
                    cnt_d = '0;
                    if (rxs) begin
                        // Good frame: the new byte always wins the holding
                        // register; an unread previous byte is reported lost.
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        if (valid_q && !read) begin
                            overrun_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        // Bad stop bit: drop the byte and wait out the low line.
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            S_BREAK: begin
                cnt_d = '0;
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Receiver state and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign dataOut  = data_q;
    assign valid    = valid_q;
    assign frameErr = frame_err_q;
    assign overrun  = overrun_q;

endmodule
